// File: rtl/mem_stage_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_sram_ctrl_if
//  Description : MEM-stage request/response and external SRAM pin bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_sram_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [31:0]       address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_dq_out;
    logic [31:0]       sram_dq_in;
    logic              sram_we_n;
    logic              sram_oe_n;

    // Controller side
    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_we_n, sram_oe_n
    );

    // Pipeline plus SRAM environment side
    modport master (
        output MEM_R_EN, MEM_W_EN, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_we_n, sram_oe_n
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_sram_ctrl
//  Description : Services LDR/STR against a fixed-latency single-port SRAM,
//                freezing the pipeline until each access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_W      = 17,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_stage_sram_ctrl_if.slave   bus
);

    localparam int                 c_cnt_w = $clog2(WAIT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic [c_cnt_w-1:0]  cnt_q,         cnt_d;
    logic [31:0]         read_data_q,   read_data_d;
    logic [ADDR_W-1:0]   sram_addr_q,   sram_addr_d;
    logic [31:0]         sram_dq_out_q, sram_dq_out_d;
    logic                sram_we_n_q,   sram_we_n_d;
    logic                sram_oe_n_q,   sram_oe_n_d;

    logic                w_req;
    logic                w_write;
    logic [31:0]         w_offset;
    logic                w_ready;

    assign w_req    = bus.MEM_R_EN | bus.MEM_W_EN;
    assign w_write  = bus.MEM_W_EN;
    assign w_offset = bus.address - 32'(BASE_ADDR);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        read_data_d   = read_data_q;
        sram_addr_d   = sram_addr_q;
        sram_dq_out_d = sram_dq_out_q;
        sram_we_n_d   = sram_we_n_q;
        sram_oe_n_d   = sram_oe_n_q;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    // Out-of-window addresses simply wrap into the SRAM.
                    sram_addr_d   = ADDR_W'(w_offset >> 2);
                    sram_dq_out_d = bus.write_data;
                    sram_we_n_d   = ~w_write;
                    sram_oe_n_d   = w_write;
                    cnt_d         = '0;
                    state_d       = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_last) begin
                    if (!sram_oe_n_q) begin
                        read_data_d = bus.sram_dq_in;
                    end
                    sram_we_n_d = 1'b1;
                    sram_oe_n_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Freeze starts combinationally in the very cycle the request shows up.
    always_comb begin
        w_ready = 1'b0;
        case (state_q)
            S_IDLE:  w_ready = ~w_req;
            S_DONE:  w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_we_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            read_data_q   <= read_data_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_we_n_q   <= sram_we_n_d;
            sram_oe_n_q   <= sram_oe_n_d;
        end
    end

    assign bus.ready       = w_ready;
    assign bus.read_data   = read_data_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = sram_dq_out_q;
    assign bus.sram_we_n   = sram_we_n_q;
    assign bus.sram_oe_n   = sram_oe_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_sram_ctrl
//  Description : Scoreboard bench for mem_stage_sram_ctrl with an SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

    localparam int WAIT = 5;
    localparam int AW   = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if #(.ADDR_W(AW)) bus ();

    mem_stage_sram_ctrl #(
        .WAIT_CYCLES (WAIT),
        .ADDR_W      (AW),
        .BASE_ADDR   (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Power-on SRAM content for words never written
    function automatic logic [31:0] init_word(input logic [31:0] idx);
        return 32'hC0DE_0000 ^ (idx * 32'h0000_9E37);
    endfunction

    // SRAM model: writes while we_n low, presents data while oe_n low
    logic [31:0] sram_mem [int];
    logic [31:0] dq_in_r = 32'h0;
    assign bus.sram_dq_in = dq_in_r;
    always @(posedge clk) begin
        #1;
        if (!bus.sram_we_n) sram_mem[int'(bus.sram_addr)] = bus.sram_dq_out;
        if (bus.sram_oe_n)
            dq_in_r = 32'h0;
        else if (sram_mem.exists(int'(bus.sram_addr)))
            dq_in_r = sram_mem[int'(bus.sram_addr)];
        else
            dq_in_r = init_word(32'(bus.sram_addr));
    end

    // Reference model: word-addressed memory plus last loaded value
    logic [31:0] ref_mem [int];
    logic [31:0] ref_last_read = 32'h0;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] rd;
        logic [31:0] dq;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_idx(input logic [31:0] a);
        return int'(((a - 32'd1024) >> 2) & 32'h0001_FFFF);
    endfunction

    task automatic model_issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        idx        = ref_idx(a);
        e.is_write = w;
        e.addr     = 32'(idx);
        e.dq       = d;
        if (w) begin
            ref_mem[idx] = d;
        end else if (r) begin
            ref_last_read = ref_mem.exists(idx) ? ref_mem[idx] : init_word(32'(idx));
        end
        e.rd = ref_last_read;
        sb.push_back(e);
    endtask

    // Called one step after a rising edge; returns one step after the edge that ends DONE
    task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        bus.MEM_R_EN   = r;
        bus.MEM_W_EN   = w;
        bus.address    = a;
        bus.write_data = d;
        model_issue(r, w, a, d);
        for (int i = 0; i < WAIT + 20; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                done = 1'b1;
                break;
            end
            if (i >= 1) begin
                bus.address    = $urandom;
                bus.write_data = $urandom;
                bus.MEM_R_EN   = 1'($urandom);
                bus.MEM_W_EN   = 1'($urandom);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL req_timeout: ready got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
    endtask

    // Monitor: measures each freeze and checks it against the scoreboard
    bit mon_en = 1'b0;
    initial begin
        int   run;
        int   we_cnt;
        int   oe_cnt;
        exp_t e;
        run = 0; we_cnt = 0; oe_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                run = 0; we_cnt = 0; oe_cnt = 0;
            end else if (!bus.ready) begin
                run++;
                if (!bus.sram_we_n) we_cnt++;
                if (!bus.sram_oe_n) oe_cnt++;
            end else if (run > 0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got response expected none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("freeze_len", 32'(run), 32'(WAIT + 1));
                    chk("sram_addr", 32'(bus.sram_addr), e.addr);
                    chk("read_data", bus.read_data, e.rd);
                    chk("we_low_cycles", 32'(we_cnt), e.is_write ? 32'(WAIT) : 32'd0);
                    chk("oe_low_cycles", 32'(oe_cnt), e.is_write ? 32'd0 : 32'(WAIT));
                    if (e.is_write) chk("sram_dq_out", bus.sram_dq_out, e.dq);
                end
                run = 0; we_cnt = 0; oe_cnt = 0;
            end else begin
                chk("idle_strobes", {30'd0, bus.sram_we_n, bus.sram_oe_n}, 32'd3);
            end
        end
    end

    initial begin
        #2_000_000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bus.MEM_R_EN   = 1'b0;
        bus.MEM_W_EN   = 1'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;

        // Reset for two cycles with no request
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_sram_addr", 32'(bus.sram_addr), 32'h0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Store, load back, back-to-back load/store, dual-enable write
        do_req(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'd1032, 32'h0);
        do_req(1'b1, 1'b0, 32'd1036, 32'h0);
        do_req(1'b0, 1'b1, 32'd1040, 32'h1234_5678);
        do_req(1'b1, 1'b1, 32'd1044, 32'hCAFE_F00D);
        do_req(1'b1, 1'b0, 32'd1044, 32'h0);
        do_req(1'b1, 1'b0, 32'd0, 32'h0);

        // Reset during the third ACCESS cycle of a load
        @(posedge clk);
        #1;
        mon_en       = 1'b0;
        bus.MEM_R_EN = 1'b1;
        bus.address  = 32'd1032;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("abort_oe_low", 32'(bus.sram_oe_n), 32'd0);
        rst          = 1'b1;
        bus.MEM_R_EN = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_last_read = 32'h0;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("abort_oe_n", 32'(bus.sram_oe_n), 32'd1);
        chk("abort_read_data", bus.read_data, 32'h0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Randomised traffic with occasional idle gaps
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            bit          r;
            bit          w;
            int          kind;
            kind = $urandom_range(0, 9);
            a    = (kind == 0) ? ($urandom & 32'hFFFF_FFFC)
                               : (32'd1024 + 32'($urandom_range(0, 15)) * 32'd4);
            case ($urandom_range(0, 2))
                0:       begin r = 1'b1; w = 1'b0; end
                1:       begin r = 1'b0; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            do_req(r, w, a, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
